// File: rtl/mac_share_sched.sv
// Round-robin scheduler sharing one pipelined multiply-add unit among NREQ requesters.
// Requester IDs ride a valid/ID shift register alongside the unit so each result returns to its owner.
module mac_share_sched #(
  parameter int NREQ = 4,
  parameter int AW   = 16,
  parameter int BW   = 16,
  parameter int CW   = 32,
  parameter int PW   = 48,
  parameter int LAT  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ*AW-1:0]         req_a,
  input  logic [NREQ*BW-1:0]         req_b,
  input  logic [NREQ*CW-1:0]         req_c,
  output logic                       ma_ce,
  output logic signed [AW-1:0]       ma_ain,
  output logic signed [BW-1:0]       ma_bin,
  output logic signed [CW-1:0]       ma_cin,
  input  logic signed [PW-1:0]       ma_pout,
  output logic [NREQ-1:0]            rsp_valid,
  output logic [$clog2(NREQ)-1:0]    rsp_id,
  output logic signed [PW-1:0]       rsp_data,
  output logic                       busy
);
  localparam int IDW = $clog2(NREQ);

  logic [IDW-1:0]        ptr_q, ptr_d;
  logic [IDW-1:0]        gnt_id;
  logic                  gnt_any;
  int                    idx;
  logic                  ma_ce_q;
  logic signed [AW-1:0]  ain_q, ain_d;
  logic signed [BW-1:0]  bin_q, bin_d;
  logic signed [CW-1:0]  cin_q, cin_d;
  logic [LAT:0]          vld_q, vld_d;
  logic [IDW-1:0]        id_q [LAT+1];
  logic [IDW-1:0]        id_d [LAT+1];

  // Rotating-priority search starting at the pointer; nothing is granted while in reset.
  always_comb begin
    gnt_any   = 1'b0;
    gnt_id    = '0;
    idx       = 0;
    req_ready = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!gnt_any && req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_id  = IDW'(idx);
      end
    end
    gnt_any = gnt_any & en & rst_n;
    if (gnt_any) req_ready[gnt_id] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) ptr_d = (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + 1'b1;
    ain_d = gnt_any ? $signed(req_a[gnt_id*AW +: AW]) : '0;
    bin_d = gnt_any ? $signed(req_b[gnt_id*BW +: BW]) : '0;
    cin_d = gnt_any ? $signed(req_c[gnt_id*CW +: CW]) : '0;
    vld_d = {vld_q[LAT-1:0], gnt_any};
    id_d[0] = gnt_id;
    for (int k = 1; k <= LAT; k++) id_d[k] = id_q[k-1];
    // The output stage only takes a new ID from a real result, so rsp_id holds across bubbles.
    if (!vld_q[LAT-1]) id_d[LAT] = id_q[LAT];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      ma_ce_q <= 1'b0;
      ain_q   <= '0;
      bin_q   <= '0;
      cin_q   <= '0;
      vld_q   <= '0;
      for (int k = 0; k <= LAT; k++) id_q[k] <= '0;
    end else begin
      ptr_q   <= ptr_d;
      ma_ce_q <= 1'b1;
      ain_q   <= ain_d;
      bin_q   <= bin_d;
      cin_q   <= cin_d;
      vld_q   <= vld_d;
      for (int k = 0; k <= LAT; k++) id_q[k] <= id_d[k];
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (vld_q[LAT]) rsp_valid[id_q[LAT]] = 1'b1;
  end

  assign ma_ce    = ma_ce_q;
  assign ma_ain   = ain_q;
  assign ma_bin   = bin_q;
  assign ma_cin   = cin_q;
  assign rsp_id   = id_q[LAT];
  assign rsp_data = ma_pout;
  assign busy     = |vld_q;

endmodule

// File: tb/tb_mac_share_sched.sv
// Bench for mac_share_sched: behavioural multiply-add unit plus a queue-based scheduling reference.
module tb_mac_share_sched;
  localparam int NREQ = 4;
  localparam int AW   = 16;
  localparam int BW   = 16;
  localparam int CW   = 32;
  localparam int PW   = 48;
  localparam int LAT  = 4;
  localparam int IDW  = 2;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    en = 1'b0;
  logic [NREQ-1:0]         req_valid = '0;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ*AW-1:0]      req_a = '0;
  logic [NREQ*BW-1:0]      req_b = '0;
  logic [NREQ*CW-1:0]      req_c = '0;
  logic                    ma_ce;
  logic signed [AW-1:0]    ma_ain;
  logic signed [BW-1:0]    ma_bin;
  logic signed [CW-1:0]    ma_cin;
  logic signed [PW-1:0]    ma_pout;
  logic [NREQ-1:0]         rsp_valid;
  logic [IDW-1:0]          rsp_id;
  logic signed [PW-1:0]    rsp_data;
  logic                    busy;

  mac_share_sched #(.NREQ(NREQ), .AW(AW), .BW(BW), .CW(CW), .PW(PW), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .ma_ce(ma_ce), .ma_ain(ma_ain), .ma_bin(ma_bin), .ma_cin(ma_cin),
    .ma_pout(ma_pout),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Shared unit: P = A*B + C, LAT cycles from operands presented to pout.
  logic signed [PW-1:0] mpipe [LAT] = '{default: '0};
  always @(posedge clk) begin
    if (ma_ce) begin
      mpipe[0] <= PW'(longint'(ma_ain) * longint'(ma_bin) + longint'(ma_cin));
      for (int k = 1; k < LAT; k++) mpipe[k] <= mpipe[k-1];
    end
  end
  assign ma_pout = mpipe[LAT-1];

  typedef struct {
    int     due;
    int     id;
    longint data;
  } rsp_t;

  rsp_t                  exp_q[$];
  int                    ptr_m = 0;
  int                    last_id_m = 0;
  int                    ecount = 0;
  int                    total = 0;
  int                    bad = 0;
  logic signed [AW-1:0]  opa [NREQ];
  logic signed [BW-1:0]  opb [NREQ];
  logic signed [CW-1:0]  opc [NREQ];

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NREQ; i++) begin
      opa[i] = 16'($urandom);
      opb[i] = 16'($urandom);
      opc[i] = 32'($urandom);
    end
  endtask

  // One clock: drive inputs, predict the grant, step the edge, then compare every output.
  task automatic cycle(input logic en_i, input logic [NREQ-1:0] v_i);
    int g;
    logic [NREQ-1:0] exp_rdy;
    logic signed [63:0] ea, eb, ec;
    rsp_t r;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*AW +: AW] = opa[i];
      req_b[i*BW +: BW] = opb[i];
      req_c[i*CW +: CW] = opc[i];
    end
    en = en_i;
    req_valid = v_i;
    #1;
    g = -1;
    if (en_i) begin
      for (int k = 0; k < NREQ; k++) begin
        int cand;
        cand = (ptr_m + k) % NREQ;
        if (g < 0 && v_i[cand]) g = cand;
      end
    end
    exp_rdy = '0;
    ea = 0; eb = 0; ec = 0;
    if (g >= 0) begin
      exp_rdy[g] = 1'b1;
      ea = 64'(opa[g]); eb = 64'(opb[g]); ec = 64'(opc[g]);
      r.due = ecount + LAT + 1;
      r.id = g;
      r.data = longint'(opa[g]) * longint'(opb[g]) + longint'(opc[g]);
      exp_q.push_back(r);
      ptr_m = (g + 1) % NREQ;
    end
    check("req_ready", 64'(req_ready), 64'(exp_rdy));
    @(posedge clk);
    #1;
    ecount++;
    check("ma_ce", 64'(ma_ce), 64'd1);
    check("ma_ain", 64'(ma_ain), ea);
    check("ma_bin", 64'(ma_bin), eb);
    check("ma_cin", 64'(ma_cin), ec);
    check("busy", 64'(busy), 64'(exp_q.size() > 0));
    if (exp_q.size() > 0 && exp_q[0].due == ecount) begin
      r = exp_q.pop_front();
      last_id_m = r.id;
      check("rsp_valid", 64'(rsp_valid), 64'(1 << r.id));
      check("rsp_data", 64'(rsp_data), r.data);
    end else begin
      check("rsp_valid_idle", 64'(rsp_valid), 64'd0);
    end
    check("rsp_id", 64'(rsp_id), 64'(last_id_m));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, '0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ma_ce"}, 64'(ma_ce), 64'd0);
    check({tag, "_ma_ain"}, 64'(ma_ain), 64'd0);
    check({tag, "_ma_bin"}, 64'(ma_bin), 64'd0);
    check({tag, "_ma_cin"}, 64'(ma_cin), 64'd0);
    check({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    check({tag, "_rsp_id"}, 64'(rsp_id), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      opa[i] = '0; opb[i] = '0; opc[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    idle(2);

    // Single op to requester 0: 3 * -4 + 5 = -7.
    opa[0] = 16'sd3; opb[0] = -16'sd4; opc[0] = 32'sd5;
    cycle(1'b1, 4'b0001);
    idle(LAT + 2);

    // All requesters continuously valid: strict rotation, back-to-back responses.
    rand_ops();
    for (int i = 0; i < 8; i++) cycle(1'b1, 4'b1111);
    idle(LAT + 2);

    // Pointer wrap after a grant to requester 3.
    cycle(1'b1, 4'b1000);
    cycle(1'b1, 4'b0101);
    cycle(1'b1, 4'b0100);
    idle(LAT + 2);

    // Most negative operands: (-32768)^2 - 2^31 = -1073741824.
    opa[1] = -16'sd32768; opb[1] = -16'sd32768; opc[1] = 32'h8000_0000;
    cycle(1'b1, 4'b0010);
    idle(LAT + 2);

    // Grant enable dropped while operations are in flight.
    rand_ops();
    cycle(1'b1, 4'b1111);
    cycle(1'b1, 4'b1111);
    for (int i = 0; i < 3; i++) cycle(1'b0, 4'b1111);
    for (int i = 0; i < LAT + 2; i++) cycle(1'b0, 4'b0000);

    // Asynchronous reset with three operations in flight.
    rand_ops();
    for (int i = 0; i < 3; i++) cycle(1'b1, 4'b1111);
    idle(2);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_q.delete();
    ptr_m = 0;
    last_id_m = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(LAT + 3);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      rand_ops();
      cycle(($urandom_range(0, 7) != 0), 4'($urandom));
    end
    for (int i = 0; i < LAT + 2; i++) cycle(1'b0, 4'b0000);
    check("drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
